// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus of the boot loader.
// The slave modport is the loader side; the master modport is the byte source / memory side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: packs streamed byte pairs (high byte first) into
// 16-bit words, writes them from address 0 upward, then verifies a trailing 16-bit checksum.
module imem_loader #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clock,
  input  logic              r_st_n,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  imem_loader_if.slave      bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       checksum
);

  localparam logic [ADDR_W:0] DEPTH_W = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_HI, S_LO, S_WRITE, S_CK_HI, S_CK_LO, S_CHECK
  } state_t;

  state_t          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [ADDR_W:0] wc_q, wc_d;
  logic [7:0]      hi_q, hi_d;
  logic [15:0]     ck_exp_q, ck_exp_d;
  logic [15:0]     sum_q, sum_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            mem_we_q, mem_we_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic            xfer;
  logic            count_legal;
  logic [ADDR_W:0] cnt_inc;

  assign xfer        = bus.byte_valid & ready_q;
  assign count_legal = (word_count != '0) && (word_count <= DEPTH_W);
  assign cnt_inc     = cnt_q + ONE_W;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wc_d     = wc_q;
    hi_d     = hi_q;
    ck_exp_d = ck_exp_q;
    sum_d    = sum_q;
    done_d   = done_q;
    err_d    = err_q;
    mem_we_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count_legal) begin
            wc_d    = word_count;
            cnt_d   = '0;
            sum_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            state_d = S_HI;
          end else begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
        end
      end
      S_HI: begin
        if (xfer) begin
          hi_d    = bus.byte_data;
          state_d = S_LO;
        end
      end
      // Write strobe, address and data are registered on entry to WRITE so they
      // are all stable for the whole strobe cycle.
      S_LO: begin
        if (xfer) begin
          wdata_d  = {hi_q, bus.byte_data};
          addr_d   = {{(16-ADDR_W){1'b0}}, cnt_q[ADDR_W-1:0]};
          mem_we_d = 1'b1;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        sum_d   = sum_q + wdata_q;
        cnt_d   = cnt_inc;
        state_d = (cnt_inc == wc_q) ? S_CK_HI : S_HI;
      end
      S_CK_HI: begin
        if (xfer) begin
          ck_exp_d[15:8] = bus.byte_data;
          state_d        = S_CK_LO;
        end
      end
      S_CK_LO: begin
        if (xfer) begin
          ck_exp_d[7:0] = bus.byte_data;
          state_d       = S_CHECK;
        end
      end
      S_CHECK: begin
        done_d  = 1'b1;
        err_d   = (ck_exp_q != sum_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_HI) || (state_d == S_LO) ||
              (state_d == S_CK_HI) || (state_d == S_CK_LO);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge r_st_n) begin
    if (!r_st_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wc_q     <= '0;
      hi_q     <= '0;
      ck_exp_q <= '0;
      sum_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wc_q     <= wc_d;
      hi_q     <= hi_d;
      ck_exp_q <= ck_exp_d;
      sum_q    <= sum_d;
      done_q   <= done_d;
      err_q    <= err_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign busy           = busy_q;
  assign cpu_hold       = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign checksum       = sum_q;

endmodule
